// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Fixed latency: XLEN shift-add or restoring-divide steps on operand magnitudes, then one
// cycle that applies sign correction and special cases and registers the result with done.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] inp1,
    input  logic [XLEN-1:0] inp2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] LastStep = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        op_q;
    // Multiply: {product high, multiplier shifting out}. Divide: {remainder, quotient/dividend}.
    logic [2*XLEN-1:0] acc_q;
    // Multiplicand magnitude or divisor magnitude.
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   dividend_q;
    logic              neg_q;
    logic              dvz_q;
    logic              ovf_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Operand decode at issue time
    logic            is_div_in;
    logic            a_signed_in;
    logic            b_signed_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;
    logic            neg_in;
    logic            ovf_in;

    // Per-cycle step and final result
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quot_signed;
    logic [XLEN-1:0]   rem_signed;
    logic [XLEN-1:0]   final_res;

    // Classify the requested op and take operand magnitudes (2^(XLEN-1) stays unsigned).
    always_comb begin
        is_div_in   = funct3[2];
        if (is_div_in) begin
            a_signed_in = ~funct3[0];
            b_signed_in = ~funct3[0];
        end else begin
            a_signed_in = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
            b_signed_in = (funct3[1:0] == 2'b01);
        end
        a_neg_in = a_signed_in & inp1[XLEN-1];
        b_neg_in = b_signed_in & inp2[XLEN-1];
        mag_a_in = a_neg_in ? (~inp1 + 1'b1) : inp1;
        mag_b_in = b_neg_in ? (~inp2 + 1'b1) : inp2;
        // Remainder follows the dividend's sign; products and quotients follow the xor.
        if (is_div_in && funct3[1]) begin
            neg_in = a_neg_in;
        end else begin
            neg_in = a_neg_in ^ b_neg_in;
        end
        ovf_in = is_div_in && !funct3[0] && (inp1 == MinNeg) && (&inp2);
    end

    // One multiply or divide iteration on the accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (op_q[2]) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (div_trial[XLEN]) begin
                acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction, result selection and divide special cases
    always_comb begin
        prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_signed = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_signed  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        final_res   = '0;
        if (!op_q[2]) begin
            if (op_q[1:0] == 2'b00) begin
                final_res = prod_signed[XLEN-1:0];
            end else begin
                final_res = prod_signed[2*XLEN-1:XLEN];
            end
        end else if (dvz_q) begin
            final_res = op_q[1] ? dividend_q : '1;
        end else if (ovf_q) begin
            final_res = op_q[1] ? '0 : MinNeg;
        end else begin
            final_res = op_q[1] ? rem_signed : quot_signed;
        end
    end

    // Control FSM with all state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            dividend_q <= '0;
            neg_q      <= 1'b0;
            dvz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StRun;
                        cnt_q      <= '0;
                        op_q       <= funct3;
                        neg_q      <= neg_in;
                        dvz_q      <= (inp2 == '0);
                        ovf_q      <= ovf_in;
                        dividend_q <= inp1;
                        if (is_div_in) begin
                            acc_q <= {{XLEN{1'b0}}, mag_a_in};
                            opb_q <= mag_b_in;
                        end else begin
                            acc_q <= {{XLEN{1'b0}}, mag_b_in};
                            opb_q <= mag_a_in;
                        end
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastStep) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    result_q <= final_res;
                    done_q   <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues expected result and done cycle per
// request; a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam int LAT = 33;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      funct3 = 3'd0;
    logic [XLEN-1:0] inp1 = '0;
    logic [XLEN-1:0] inp2 = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .inp1   (inp1),
        .inp2   (inp2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busy stuck for %0d cycles, expected idle", name, n);
        end
    endtask

    // b2b: issue in the current (done) cycle instead of waiting one more cycle
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input string name, input bit b2b);
        if (!b2b) @(negedge clk);
        funct3 = f;
        inp1   = a;
        inp2   = b;
        start  = 1'b1;
        sb.push_back('{exp_res, cyc + 1 + LAT, name});
        @(negedge clk);
        start  = 1'b0;
        inp1   = $urandom;
        inp2   = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        wait_idle(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'h0);
        rst = 1'b0;

        // Multiply
        issue(3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3", 1'b0);
        issue(3'b000, 32'h12345678,  32'd9,        32'hA3D70A38, "mul_big", 1'b1);
        issue(3'b001, 32'h80000000,  32'h80000000, 32'h40000000, "mulh_min", 1'b0);
        issue(3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max", 1'b0);
        issue(3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_max", 1'b0);
        issue(3'b001, 32'hFFFFFFFF,  32'd7,        32'hFFFFFFFF, "mulh_m1_7", 1'b0);
        issue(3'b011, 32'h80000000,  32'd4,        32'h00000002, "mulhu_shift", 1'b0);

        // Divide
        issue(3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, "div_m7_2", 1'b0);
        issue(3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, "rem_m7_2", 1'b0);
        issue(3'b101, 32'd100,       32'd7,        32'd14,       "divu_100_7", 1'b0);
        issue(3'b111, 32'd100,       32'd7,        32'd2,        "remu_100_7", 1'b1);
        issue(3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2", 1'b0);
        issue(3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        "rem_7_m2", 1'b0);

        // Divide special cases
        issue(3'b101, 32'h1234,      32'd0,        32'hFFFFFFFF, "divu_by0", 1'b0);
        issue(3'b110, 32'h1234,      32'd0,        32'h1234,     "rem_by0", 1'b0);
        issue(3'b100, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, "div_neg_by0", 1'b0);
        issue(3'b110, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, "rem_neg_by0", 1'b0);
        issue(3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, "div_ovf", 1'b0);
        issue(3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h0,        "rem_ovf", 1'b0);

        // start held high through RUN/DONE with changing operands
        @(negedge clk);
        funct3 = 3'b000;
        inp1   = 32'd3;
        inp2   = 32'd5;
        start  = 1'b1;
        sb.push_back('{32'd15, cyc + 1 + LAT, "held_first"});
        @(negedge clk);
        inp1 = 32'd9;
        inp2 = 32'd9;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("held_busy_cycles", 32'(n), 32'd33);
        // start is still high in this idle cycle, so the second op launches now
        sb.push_back('{32'd81, cyc + 1 + LAT, "held_second"});
        @(negedge clk);
        start = 1'b0;
        wait_idle("held_second");

        // Reset in the middle of RUN
        @(negedge clk);
        funct3 = 3'b000;
        inp1   = 32'd123;
        inp2   = 32'd456;
        start  = 1'b1;
        sb.push_back('{32'd56088, cyc + 1 + LAT, "aborted"});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'h0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (45) begin
            @(negedge clk);
            if (busy !== 1'b0) n++;
        end
        check("abort_stays_idle", 32'(n), 32'd0);
        issue(3'b101, 32'd100, 32'd7, 32'd14, "after_reset", 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
